refill_arbiter: RTL and testbench
=================================

Name: refill_arbiter

Overview:
- Shares one AXI4 read channel between the I-cache and D-cache line-refill ports.
- Grants one requester at a time and issues a single INCR burst of one cache line.
- Collects the returned beats into a line buffer, then pulses that requester's gnt.
- Sits between the two cache instances and the CPU top-level AXI master.

Parameters:
- OFFSET_LEN, 5, log2 of line bytes; LINE_WORDS = 1<<(OFFSET_LEN-2) = 8, so arlen = LINE_WORDS-1.
- ADDR_W, 32, address width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- i_req  in  1  I-cache refill request; held high until i_gnt.
- i_addr  in  ADDR_W  I-cache line address; low OFFSET_LEN bits are zero.
- i_gnt  out  1  one-cycle pulse: line data for I-cache is valid.
- d_req  in  1  D-cache refill request.
- d_addr  in  ADDR_W  D-cache line address.
- d_gnt  out  1  one-cycle pulse for D-cache.
- line_data  out  32*LINE_WORDS  line buffer; word k at bits [32k+31:32k]; shared by both caches.
- arid  out  4  0 = I-cache, 1 = D-cache.
- araddr  out  ADDR_W  burst start address.
- arlen  out  8  constant LINE_WORDS-1.
- arsize  out  3  constant 3'b010.
- arburst  out  2  constant 2'b01 (INCR).
- arvalid  out  1  AR valid.
- arready  in  1  AR ready.
- rdata  in  32  read data.
- rlast  in  1  last beat.
- rvalid  in  1  R valid.
- rready  out  1  R ready.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; arvalid, rready, i_gnt, d_gnt = 0.
  - araddr, arid, beat counter = 0; line_data = 0; owner = I.
  - Reset mid-burst abandons the transfer. No gnt is issued.
- IDLE:
  - If any req is high, select a winner, latch its addr into araddr and its id into arid, record owner, go to AR.
  - Default arbitration is fixed priority: D-cache wins when both are requesting.
  - Arbitration is decided in IDLE only; a request arriving later waits.
- AR:
  - arvalid = 1; araddr and arid stay stable until arready.
  - On arvalid && arready, clear the beat counter and go to R.
  - No AR is issued while a burst is outstanding (at most one outstanding).
- R:
  - rready = 1.
  - Each cycle with rvalid && rready, write rdata into line_data word[cnt] and increment cnt (3 bits, wraps).
  - Completion occurs on the accepted beat with rlast, or the beat with cnt == LINE_WORDS-1, whichever comes first.
  - Early rlast leaves the unreceived words holding stale data.
  - rid and rresp are ignored.
  - On completion go to DONE.
- DONE:
  - Pulse the owner's gnt (i_gnt or d_gnt) for exactly one cycle; rready = 0; next state is IDLE.
  - The granted cache drops req in the cycle after gnt, so that requester is not re-arbitrated in that IDLE.
- Data hold:
  - line_data is stable from the gnt cycle until the first R beat of the next burst.
  - This is at least 2 cycles after gnt, so the cache can write its banks in the cycle after gnt.
- Latency:
  - Minimum from req to gnt is 1 (IDLE) + 1 (AR) + LINE_WORDS (R) + gnt cycle = 11 cycles, with arready and rvalid tied high.
- Invariants:
  - Never both gnts in the same cycle.
  - A gnt is never issued without a preceding AR handshake.
  - A req dropped before gnt is a protocol violation; the burst still completes and gnt still pulses.

Optional Feature:
- REFILL_RR_EN defined: round-robin arbitration. A 1-bit last_owner register, reset to I, gives priority to the requester other than last_owner when both are high. last_owner updates in DONE.
- REFILL_RR_EN undefined: fixed D-over-I priority as described above. The last_owner register is absent.

Test Plan:
- I-only refill: i_req=1, i_addr=0xBFC00020, arready=1, 8 beats of data 0x100..0x107 with rlast on the 8th → araddr=0xBFC00020, arid=0, arlen=7; i_gnt pulses once at cycle 11; line_data word3=0x103; d_gnt stays 0.
- Simultaneous requests, fixed priority: i_req=d_req=1 with addrs 0x1000 and 0x2000 → first AR is 0x2000 with arid=1; d_gnt pulses; then AR 0x1000 with arid=0; i_gnt pulses.
- Simultaneous requests with REFILL_RR_EN defined: both requesters held high across four refills → grants alternate D,I,D,I (first D, since last_owner resets to I).
- Backpressure: arready low for 5 cycles, then rvalid toggling 1,0,1,0 → araddr stable throughout AR; exactly 8 words captured in order; gnt occurs one cycle after the 8th accepted beat.
- Early rlast on beat 4 (rdata 0xA0..0xA3) → gnt issued after beat 4; words 4..7 keep the previous line's values.
- Reset mid-burst: rst_n low after beat 3 → arvalid, rready, gnt, line_data = 0 immediately; after release with i_req high, a fresh AR is issued and the full burst completes normally.

Source files
------------

// File: rtl/refill_arbiter_if.sv
// refill_arbiter_if: cache refill ports plus the AXI4 read channel of the refill arbiter
// master: the arbiter side (takes cache requests, drives AR and R ready, returns the line)
// slave : the surrounding side (the two caches together with the AXI read slave)
// Parameters: OFFSET_LEN = log2 of line bytes, ADDR_W = address width
interface refill_arbiter_if #(
    parameter int OFFSET_LEN = 5,
    parameter int ADDR_W     = 32
);
    localparam int LINE_WORDS = 1 << (OFFSET_LEN - 2);
    logic                    i_req;
    logic [ADDR_W-1:0]       i_addr;
    logic                    i_gnt;
    logic                    d_req;
    logic [ADDR_W-1:0]       d_addr;
    logic                    d_gnt;
    logic [32*LINE_WORDS-1:0] line_data;
    logic [3:0]              arid;
    logic [ADDR_W-1:0]       araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arvalid;
    logic                    arready;
    logic [31:0]             rdata;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;
    modport master (
        input  i_req, i_addr, d_req, d_addr, arready, rdata, rlast, rvalid,
        output i_gnt, d_gnt, line_data, arid, araddr, arlen, arsize, arburst, arvalid, rready
    );
    modport slave (
        output i_req, i_addr, d_req, d_addr, arready, rdata, rlast, rvalid,
        input  i_gnt, d_gnt, line_data, arid, araddr, arlen, arsize, arburst, arvalid, rready
    );
endinterface

// File: rtl/refill_arbiter.sv
// refill_arbiter: shares one AXI4 read channel between the I-cache and D-cache line refills
// Ports: clk, rst_n (async active-low), bus (refill_arbiter_if.master):
//   i_req/i_addr/i_gnt, d_req/d_addr/d_gnt : per-cache refill request, line address, grant pulse
//   line_data                               : shared line buffer, word k at [32k+31:32k]
//   ar*/r*                                  : AXI4 read address and read data channels
// Define REFILL_RR_EN for round-robin arbitration; otherwise D-cache has fixed priority.
module refill_arbiter #(
    parameter int OFFSET_LEN = 5,
    parameter int ADDR_W     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    refill_arbiter_if.master bus
);
    localparam int LINE_WORDS = 1 << (OFFSET_LEN - 2);
    localparam int CNT_W      = OFFSET_LEN - 2;
    typedef enum logic [1:0] {IDLE, AR, R, DONE} state_t;
    state_t                      state, state_nx;
    logic [CNT_W-1:0]            cnt;
    logic [LINE_WORDS-1:0][31:0] line_q;
    logic [ADDR_W-1:0]           addr_sel;
    logic                        owner;
    logic                        pick_d;
    logic                        any_req;
    logic                        beat;
    logic                        last_beat;
`ifdef REFILL_RR_EN
    logic last_owner;
    // when both request, the one not served last time wins
    assign pick_d = bus.d_req && (!bus.i_req || !last_owner);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_owner <= 1'b0;
        else if (state == DONE)
            last_owner <= owner;
    end
`else
    assign pick_d = bus.d_req;
`endif
    assign any_req   = bus.i_req || bus.d_req;
    assign addr_sel  = pick_d ? bus.d_addr : bus.i_addr;
    assign beat      = bus.rvalid && bus.rready;
    // an all-ones counter means this beat fills the last word even if rlast never comes
    assign last_beat = beat && (bus.rlast || &cnt);
    assign bus.line_data = line_q;
    assign bus.arlen     = 8'(LINE_WORDS - 1);
    assign bus.arsize    = 3'b010;
    assign bus.arburst   = 2'b01;
    always_comb begin
        state_nx    = state;
        bus.arvalid = 1'b0;
        bus.rready  = 1'b0;
        bus.i_gnt   = 1'b0;
        bus.d_gnt   = 1'b0;
        unique case (state)
            IDLE:    state_nx = any_req ? AR : IDLE;
            AR:      state_nx = bus.arready ? R : AR;
            R:       state_nx = last_beat ? DONE : R;
            default: state_nx = IDLE;
        endcase
        bus.arvalid = state == AR;
        bus.rready  = state == R;
        bus.i_gnt   = state == DONE && !owner;
        bus.d_gnt   = state == DONE && owner;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            line_q     <= '0;
            owner      <= 1'b0;
            bus.araddr <= '0;
            bus.arid   <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && any_req) begin
                bus.araddr <= addr_sel;
                bus.arid   <= {3'b000, pick_d};
                owner      <= pick_d;
            end
            if (state == AR && bus.arready)
                cnt <= '0;
            if (beat) begin
                line_q[cnt] <= bus.rdata;
                cnt         <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_refill_arbiter.sv
// tb_refill_arbiter: directed and randomized refills against a transaction-level line model
module tb_refill_arbiter;
    localparam int OFFSET_LEN = 5;
    localparam int ADDR_W     = 32;
    localparam int LW         = 8;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    refill_arbiter_if #(.OFFSET_LEN(OFFSET_LEN), .ADDR_W(ADDR_W)) bus ();
    refill_arbiter #(.OFFSET_LEN(OFFSET_LEN), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );
    int          vectors = 0;
    int          errs    = 0;
    logic [31:0] mline [LW];
    bit          last_d  = 1'b0;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask
    function automatic logic [255:0] pack_line();
        logic [255:0] v;
        for (int k = 0; k < LW; k++) v[32*k +: 32] = mline[k];
        return v;
    endfunction
    function automatic bit want_d(input bit ir, input bit dr);
        if (ir && dr) begin
`ifdef REFILL_RR_EN
            return !last_d;
`else
            return 1'b1;
`endif
        end
        return dr;
    endfunction
    // Acts as AXI slave for one refill. vmode: 0 rvalid held high, 1 toggling, 2 random.
    // dbase < 0 gives random data. abort_at > 0 resets the DUT after that many beats.
    task automatic serve(input logic [31:0] ea, input bit ed, input int ar_wait, input int last_at,
                         input int vmode, input int dbase, input int abort_at, input bit drop,
                         output int lat);
        bit p_arv, p_rr, hs, fin, ar_chk, lastnow;
        int beats, arw, tg;
        hs = 0; fin = 0; ar_chk = 0; beats = 0; arw = 0; tg = 0; lat = 0;
        bus.arready = (ar_wait == 0);
        bus.rvalid  = 1'b0;
        bus.rlast   = 1'b0;
        bus.rdata   = '0;
        for (int c = 0; c < 300 && !fin; c++) begin
            p_arv = bus.arvalid;
            p_rr  = bus.rready;
            tick();
            lat++;
            lastnow = 1'b0;
            if (p_arv && bus.arready) hs = 1'b1;
            if (p_rr && bus.rvalid) begin
                mline[beats] = bus.rdata;
                beats++;
                lastnow = (beats == last_at);
            end
            if (abort_at > 0 && beats == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_arvalid", bus.arvalid, 0);
                chk("rst_rready", bus.rready, 0);
                chk("rst_gnt", {bus.d_gnt, bus.i_gnt}, 0);
                chk("rst_line", bus.line_data, 0);
                chk("rst_araddr", bus.araddr, 0);
                for (int k = 0; k < LW; k++) mline[k] = '0;
                last_d = 1'b0;
                bus.arready = 1'b0;
                bus.rvalid  = 1'b0;
                bus.rlast   = 1'b0;
                tick();
                tick();
                rst_n = 1'b1;
                return;
            end
            if (bus.i_gnt || bus.d_gnt) begin
                fin = 1'b1;
                chk("gnt_owner", {bus.d_gnt, bus.i_gnt}, ed ? 2'b10 : 2'b01);
                chk("gnt_after_ar", hs, 1);
                chk("gnt_timing", lastnow, 1);
                chk("line_at_gnt", bus.line_data, pack_line());
                last_d = ed;
                if (drop) begin
                    if (ed) bus.d_req = 1'b0;
                    else bus.i_req = 1'b0;
                end
                bus.arready = 1'b0;
                bus.rvalid  = 1'b0;
                bus.rlast   = 1'b0;
                tick();
                chk("gnt_pulse", {bus.d_gnt, bus.i_gnt}, 0);
                chk("line_hold", bus.line_data, pack_line());
            end else begin
                if (bus.arvalid) begin
                    chk("ar_addr", bus.araddr, ea);
                    chk("ar_id", bus.arid, {3'b000, ed});
                    if (!ar_chk) begin
                        chk("ar_len", bus.arlen, 7);
                        chk("ar_size", bus.arsize, 3'b010);
                        chk("ar_burst", bus.arburst, 2'b01);
                        ar_chk = 1'b1;
                    end
                    if (arw >= ar_wait) bus.arready = 1'b1;
                    else begin
                        bus.arready = 1'b0;
                        arw++;
                    end
                end
                if (bus.rready) begin
                    chk("no_ar_in_r", bus.arvalid, 0);
                    tg++;
                    bus.rvalid = (beats < last_at) &&
                                 (vmode == 0 || (vmode == 1 && tg[0]) ||
                                  (vmode == 2 && $urandom_range(0, 1) == 1));
                    bus.rdata  = (dbase < 0) ? $urandom : 32'(dbase + beats);
                    bus.rlast  = (beats + 1 == last_at);
                end
            end
        end
        if (!fin) chk("gnt_timeout", 0, 1);
    endtask
    initial begin
        int          lat, r, la, aw;
        bit          wd;
        logic [31:0] ia, da;
        bus.i_req = 0; bus.d_req = 0; bus.i_addr = 0; bus.d_addr = 0;
        bus.arready = 0; bus.rvalid = 0; bus.rlast = 0; bus.rdata = 0;
        for (int k = 0; k < LW; k++) mline[k] = '0;
        tick();
        tick();
        chk("reset_arvalid", bus.arvalid, 0);
        chk("reset_rready", bus.rready, 0);
        chk("reset_gnt", {bus.d_gnt, bus.i_gnt}, 0);
        chk("reset_line", bus.line_data, 0);
        chk("reset_arid", bus.arid, 0);
        rst_n = 1'b1;
        tick();
        // single I-cache refill with everything ready
        bus.i_addr = 32'hBFC0_0020;
        bus.i_req  = 1'b1;
        serve(32'hBFC0_0020, 1'b0, 0, 8, 0, 'h100, 0, 1'b1, lat);
        chk("latency", lat, 10);
        chk("word3", bus.line_data[127:96], 32'h103);
        // both request together, winner then loser
        bus.i_addr = 32'h1000; bus.d_addr = 32'h2000;
        bus.i_req = 1'b1; bus.d_req = 1'b1;
        wd = want_d(1, 1);
        chk("first_winner_d", wd, 1);
        serve(wd ? 32'h2000 : 32'h1000, wd, 0, 8, 0, -1, 0, 1'b1, lat);
        wd = want_d(bus.i_req, bus.d_req);
        serve(wd ? 32'h2000 : 32'h1000, wd, 0, 8, 0, -1, 0, 1'b1, lat);
        // both held across four refills
        bus.i_req = 1'b1; bus.d_req = 1'b1;
        for (int n = 0; n < 4; n++) begin
            wd = want_d(1, 1);
            serve(wd ? 32'h2000 : 32'h1000, wd, 0, 8, 0, -1, 0, 1'b0, lat);
        end
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        tick();
        // AR backpressure and toggling rvalid
        bus.d_addr = 32'h0000_3A40;
        bus.d_req  = 1'b1;
        serve(32'h0000_3A40, 1'b1, 5, 8, 1, 'h5000, 0, 1'b1, lat);
        tick();
        // early rlast on beat 4
        bus.i_addr = 32'h0000_0C00;
        bus.i_req  = 1'b1;
        serve(32'h0000_0C00, 1'b0, 0, 4, 0, 'hA0, 0, 1'b1, lat);
        chk("early_word5", bus.line_data[191:160], 32'h5005);
        tick();
        // reset mid-burst, then a clean refill
        bus.i_addr = 32'h0000_4E00;
        bus.i_req  = 1'b1;
        serve(32'h0000_4E00, 1'b0, 0, 8, 0, -1, 3, 1'b1, lat);
        serve(32'h0000_4E00, 1'b0, 0, 8, 0, -1, 0, 1'b1, lat);
        chk("post_reset_latency", lat, 10);
        // randomized refills
        for (int n = 0; n < 20; n++) begin
            r  = $urandom_range(1, 3);
            ia = $urandom & ~32'h1F;
            da = $urandom & ~32'h1F;
            aw = $urandom_range(0, 3);
            la = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : 8;
            bus.i_addr = ia; bus.d_addr = da;
            bus.i_req = r[0]; bus.d_req = r[1];
            wd = want_d(r[0], r[1]);
            serve(wd ? da : ia, wd, aw, la, 2, -1, 0, 1'b1, lat);
            bus.i_req = 1'b0; bus.d_req = 1'b0;
            tick();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
